oled_i2c_master_tx: RTL and testbench
=====================================

// Module: oled_i2c_master_tx
// PURPOSE
//  Byte-oriented I2C master transmitter driving the SSD1306 OLED bus (oled_scl / oled_sda).
//  Accepts command/data bytes over a valid/ready handshake and generates START, repeated START,
//  8 data bits MSB-first, the ACK slot and STOP. Top level wraps SDA open-drain:
//  oled_sda = sda_drive_low ? 1'b0 : 1'bz; oled_scl = scl_o. Write-only; no clock stretching.
// PARAMETERS
//  CLK_HZ   50_000_000  system clock frequency
//  I2C_HZ   400_000     target SCL rate; QDIV = CLK_HZ/(4*I2C_HZ), integer division (31 -> ~403 kHz)
// PORTS
//  clk_50         in   1  system clock
//  rst_n          in   1  reset, asynchronous, active-low
//  tx_data        in   8  byte to send
//  tx_start       in   1  generate START (or repeated START) before this byte
//  tx_stop        in   1  generate STOP after this byte's ACK slot
//  tx_valid       in   1  byte/flags valid
//  tx_ready       out  1  block can accept a byte this cycle
//  busy           out  1  bus owned (START issued, STOP not yet completed)
//  nack_err       out  1  slave NACK seen (sticky; see CONFIGURATION)
//  scl_o          out  1  SCL level
//  sda_drive_low  out  1  1 = pull SDA low, 0 = release
//  sda_in         in   1  SDA pad readback (async; 2-flop synchronised inside)
// BEHAVIOUR
//  - Reset values: scl_o=1, sda_drive_low=0, busy=0, tx_ready=1, nack_err=0, state IDLE, qtick count 0.
//  - Timing unit: quarter period Q = QDIV clocks. Quarter counter held at 0 in IDLE/HOLD, so the first
//    phase begins the cycle after acceptance.
//  - Handshake: tx_ready=1 only in IDLE and HOLD; transfer when tx_valid&&tx_ready; byte+flags latched.
//    tx_valid while tx_ready=0 is ignored. tx_ready drops the cycle after acceptance.
//  - States: IDLE, START, RSTART, DATA, ACK, HOLD, STOP.
//  - IDLE: SCL=1, SDA released. Accept -> START (tx_start ignored; START always issued from IDLE).
//  - START (2Q): Q0 SDA released, SCL=1; Q1 SDA low, SCL=1; exit with SCL low. busy=1 from acceptance.
//  - RSTART (4Q, from HOLD when tx_start=1): Q0 SCL low, SDA released; Q1 SCL high; Q2 SDA low, SCL high;
//    Q3 SCL low. Then DATA.
//  - DATA (8 bits x 4Q): per bit Q0-Q1 SCL low (SDA updated at start of Q0), Q2-Q3 SCL high. MSB first.
//  - ACK (4Q): SDA released; synchronised sda_in sampled at last clock of Q2 (mid-high). 0 = ACK.
//  - After ACK: tx_stop=1 -> STOP; else -> HOLD (SCL low, SDA low, busy=1, tx_ready=1, waits indefinitely).
//  - HOLD accept: tx_start=1 -> RSTART, else -> DATA directly.
//  - STOP (4Q): Q0 SCL low, SDA low; Q1 SCL high, SDA low; Q2-Q3 SCL high, SDA released (bus-free time).
//    Then IDLE, busy=0, tx_ready=1 same cycle.
//  - Latency, single byte with start+stop: 2Q+32Q+4Q+4Q = 42Q = 1302 clocks (QDIV=31), accept to IDLE.
//  - SDA never changes while SCL high except START/RSTART/STOP edges.
//  - Reset mid-operation: outputs return to reset values immediately (bus released, may leave slave
//    mid-byte); next byte after reset begins with a fresh START.
// CONFIGURATION
//  - Macro OLED_I2C_ACK_CHECK_EN:
//    defined: sampled NACK sets nack_err=1 and forces STOP regardless of tx_stop; nack_err clears on the
//      next accepted byte from IDLE.
//    undefined: ACK slot still clocked, sample ignored; nack_err tied 0; flow follows tx_stop only.
// STRUCTURE
//  - Package oled_i2c_pkg: i2c_state_t enum, function qdiv(clk_hz,i2c_hz), SSD1306_ADDR_W = 8'h78,
//    control bytes SSD1306_CTRL_CMD = 8'h00, SSD1306_CTRL_DATA = 8'h40.
//  - Sub-module i2c_qtick: QDIV-wide counter with clear input, emits 1-cycle quarter tick and 2-bit phase.
//  - Top FSM, shift register (8b), bit counter (3b), sda_in 2-flop synchroniser in oled_i2c_master_tx.
// TESTING (bench model: I2C slave decoder on scl_o/SDA, configurable ACK/NACK, QDIV=31)
//  1. Reset asserted -> scl_o=1, sda_drive_low=0, tx_ready=1, busy=0, nack_err=0.
//  2. 0x78 start+stop, slave ACKs -> decoder sees START,0x78,ACK,STOP; IDLE exactly 1302 clocks after accept.
//  3. 0x78 start/no-stop, then 0x00, then 0xAF stop -> HOLD between bytes (tx_ready=1, SCL low),
//     no START between, decoded 0x78,0x00,0xAF,STOP; busy=1 throughout.
//  4. In HOLD, next byte 0x79 with tx_start=1 -> repeated START detected before 0x79, no STOP before it.
//  5. Slave NACKs 0x78 with tx_stop=0: macro defined -> nack_err=1, STOP, IDLE; undefined -> nack_err=0, HOLD.
//  6. rst_n pulsed during bit 3 of 0xA5 -> outputs at reset values same cycle; following 0x78 start+stop
//     decodes cleanly. tx_valid held high while busy in DATA -> no extra bytes accepted.

Source files
------------

// File: rtl/oled_i2c_pkg.sv
// oled_i2c_pkg: shared FSM state type, SCL divider helper and SSD1306 byte constants
package oled_i2c_pkg;
  typedef enum logic [2:0] {IDLE, START, RSTART, DATA, ACK, HOLD, STOP} i2c_state_t;
  localparam logic [7:0] SSD1306_ADDR_W    = 8'h78;
  localparam logic [7:0] SSD1306_CTRL_CMD  = 8'h00;
  localparam logic [7:0] SSD1306_CTRL_DATA = 8'h40;
  function automatic int qdiv(input int clk_hz, input int i2c_hz);
    return clk_hz / (4 * i2c_hz);
  endfunction
endpackage

// File: rtl/oled_i2c_master_tx_if.sv
// oled_i2c_master_tx_if: byte handshake and status between a client and the I2C transmitter
interface oled_i2c_master_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_stop;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       nack_err;
  modport master (output tx_data, tx_start, tx_stop, tx_valid, input tx_ready, busy, nack_err);
  modport slave  (input tx_data, tx_start, tx_stop, tx_valid, output tx_ready, busy, nack_err);
endinterface

// File: rtl/oled_i2c_master_tx_qtick.sv
// i2c_qtick: quarter-period divider emitting a one-cycle tick and a 2-bit quarter phase
module i2c_qtick #(
  parameter int QDIV = 31
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       i_clr,
  output logic       o_tick,
  output logic [1:0] o_phase
);
  localparam int CW = QDIV > 1 ? $clog2(QDIV) : 1;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_phase;
  assign o_tick  = r_cnt == CW'(QDIV - 1);
  assign o_phase = r_phase;
  always_ff @(posedge clk_50 or negedge rst_n)
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= '0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_phase <= '0;
    end else if (o_tick) begin
      r_cnt   <= '0;
      r_phase <= r_phase + 2'd1;
    end else
      r_cnt <= r_cnt + CW'(1);
endmodule

// File: rtl/oled_i2c_master_tx.sv
// oled_i2c_master_tx: write-only I2C master for the SSD1306 bus; OLED_I2C_ACK_CHECK_EN turns slave NACK into error+STOP
module oled_i2c_master_tx
  import oled_i2c_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int I2C_HZ = 400_000
) (
  input  logic                    clk_50,
  input  logic                    rst_n,
  oled_i2c_master_tx_if.slave     tx,
  output logic                    scl_o,
  output logic                    sda_drive_low,
  input  logic                    sda_in
);
`ifdef OLED_I2C_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif
  localparam int QDIV = qdiv(CLK_HZ, I2C_HZ);
  i2c_state_t r_state, w_next;
  logic [7:0] r_shift;
  logic [2:0] r_bit;
  logic       r_stop, r_nack, r_nack_err, r_sda_s1, r_sda_s2;
  logic       w_tick, w_clr, w_acc, w_q_end, w_ack_smp;
  logic [1:0] w_phase;
  assign w_acc     = tx.tx_valid && tx.tx_ready;
  assign w_q_end   = w_tick && w_phase == 2'd3;
  assign w_ack_smp = r_state == ACK && w_tick && w_phase == 2'd2;
  // phase restarts at 0 on every state entry; DATA bits wrap 3->0 on their own
  assign w_clr     = r_state == IDLE || r_state == HOLD || w_next != r_state;
  i2c_qtick #(.QDIV(QDIV)) u_qtick (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .o_tick (w_tick),
    .o_phase(w_phase)
  );
  always_ff @(posedge clk_50 or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next        = r_state;
    scl_o         = 1'b1;
    sda_drive_low = 1'b0;
    case (r_state)
      IDLE:   w_next = w_acc ? START : IDLE;
      START: begin
        w_next        = (w_tick && w_phase == 2'd1) ? DATA : START;
        sda_drive_low = w_phase == 2'd1;
      end
      RSTART: begin
        w_next        = w_q_end ? DATA : RSTART;
        scl_o         = w_phase == 2'd1 || w_phase == 2'd2;
        sda_drive_low = w_phase[1];
      end
      DATA: begin
        w_next        = (w_q_end && r_bit == 3'd7) ? ACK : DATA;
        scl_o         = w_phase[1];
        sda_drive_low = ~r_shift[7];
      end
      ACK: begin
        w_next = w_q_end ? ((r_stop || (ACK_CHK && r_nack)) ? STOP : HOLD) : ACK;
        scl_o  = w_phase[1];
      end
      HOLD: begin
        w_next        = w_acc ? (tx.tx_start ? RSTART : DATA) : HOLD;
        scl_o         = 1'b0;
        sda_drive_low = 1'b1;
      end
      STOP: begin
        w_next        = w_q_end ? IDLE : STOP;
        scl_o         = w_phase != 2'd0;
        sda_drive_low = ~w_phase[1];
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_50 or negedge rst_n)
    if (!rst_n) begin
      r_shift    <= '0;
      r_bit      <= '0;
      r_stop     <= 1'b0;
      r_nack     <= 1'b0;
      r_nack_err <= 1'b0;
      r_sda_s1   <= 1'b1;
      r_sda_s2   <= 1'b1;
    end else begin
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
      if (w_acc) begin
        r_shift <= tx.tx_data;
        r_stop  <= tx.tx_stop;
        r_bit   <= '0;
      end else if (r_state == DATA && w_q_end) begin
        r_shift <= {r_shift[6:0], 1'b0};
        r_bit   <= r_bit + 3'd1;
      end
      if (w_ack_smp) r_nack <= r_sda_s2;
      if (w_acc && r_state == IDLE) r_nack_err <= 1'b0;
      else if (ACK_CHK && w_ack_smp && r_sda_s2) r_nack_err <= 1'b1;
    end
  assign tx.tx_ready = r_state == IDLE || r_state == HOLD;
  assign tx.busy     = r_state != IDLE;
  assign tx.nack_err = ACK_CHK && r_nack_err;
endmodule

// File: tb/tb_oled_i2c_master_tx.sv
// tb_oled_i2c_master_tx: table-driven transactions checked by an I2C slave decoder and token scoreboard
module tb_oled_i2c_master_tx;
  import oled_i2c_pkg::*;
`ifdef OLED_I2C_ACK_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int T_START = 256, T_RSTART = 512, T_STOP = 768, T_ACK = 1024, T_NACK = 1280;
  typedef struct {
    logic [7:0] d;
    bit st, sp, ack;
    bit exp_idle, exp_nack;
  } vec_t;
  logic clk_50 = 1'b0, rst_n, scl_o, sda_drive_low;
  logic slave_pull = 1'b0;
  bit   mute = 1'b1, ack_en = 1'b1;
  wire  sda_line = ~(sda_drive_low | slave_pull);
  int   n_vec = 0, n_err = 0;
  int   exp_q[$];
  oled_i2c_master_tx_if intf();
  oled_i2c_master_tx dut (
    .clk_50       (clk_50),
    .rst_n        (rst_n),
    .tx           (intf),
    .scl_o        (scl_o),
    .sda_drive_low(sda_drive_low),
    .sda_in       (sda_line)
  );
  always #10 clk_50 = ~clk_50;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // slave decoder: samples the bus on the falling clock edge, acks when enabled
  logic [7:0] sr;
  int bitn;
  bit active, pscl, psda;
  task automatic got(input int tok);
    int e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL token: got %0h expected none", tok);
    end else begin
      e = exp_q.pop_front();
      chk("token", tok, e);
    end
  endtask
  always @(negedge clk_50) begin
    logic l;
    if (mute) begin
      bitn = 0; active = 1'b0; pscl = 1'b1; psda = 1'b1; slave_pull = 1'b0;
    end else begin
      l = ~(sda_drive_low | slave_pull);
      if (pscl && scl_o && psda && !l) begin
        got(active ? T_RSTART : T_START);
        active = 1'b1;
        bitn = 0;
      end else if (pscl && scl_o && !psda && l) begin
        got(T_STOP);
        active = 1'b0;
        bitn = 0;
      end else if (!pscl && scl_o) begin
        if (bitn < 8) begin
          sr = {sr[6:0], l};
          bitn++;
        end else begin
          got((l ? T_NACK : T_ACK) + int'(sr));
          bitn = 0;
        end
      end else if (pscl && !scl_o)
        slave_pull = (bitn == 8) && ack_en;
      pscl = scl_o;
      psda = l;
    end
  end
  task automatic send(input logic [7:0] d, input bit st, input bit sp);
    int k = 0;
    @(negedge clk_50);
    while (!intf.tx_ready && k < 5000) begin
      @(negedge clk_50);
      k++;
    end
    chk("ready_before_send", intf.tx_ready, 1'b1);
    intf.tx_data  = d;
    intf.tx_start = st;
    intf.tx_stop  = sp;
    intf.tx_valid = 1'b1;
    @(posedge clk_50);
    #1 intf.tx_valid = 1'b0;
  endtask
  task automatic wait_ready();
    int k = 0;
    while (!intf.tx_ready && k < 5000) begin
      @(negedge clk_50);
      k++;
    end
    chk("ready_timeout", intf.tx_ready, 1'b1);
  endtask
  task automatic chk_rst(input string nm);
    chk({nm, "_scl"}, scl_o, 1'b1);
    chk({nm, "_sda"}, sda_drive_low, 1'b0);
    chk({nm, "_ready"}, intf.tx_ready, 1'b1);
    chk({nm, "_busy"}, intf.busy, 1'b0);
    chk({nm, "_nack"}, intf.nack_err, 1'b0);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t v[8];
    bit idle_m;
    int cnt, extra;
    v[0] = '{SSD1306_ADDR_W,    1, 0, 1, 0, 0};
    v[1] = '{SSD1306_CTRL_CMD,  0, 0, 1, 0, 0};
    v[2] = '{8'hAF,             0, 1, 1, 1, 0};
    v[3] = '{SSD1306_ADDR_W,    1, 0, 1, 0, 0};
    v[4] = '{8'h79,             1, 1, 1, 1, 0};
    v[5] = '{SSD1306_ADDR_W,    1, 0, 0, CHK, CHK};
    v[6] = '{SSD1306_CTRL_DATA, 1, 1, 1, 1, 0};
    v[7] = '{8'hA5,             1, 1, 1, 1, 0};
    rst_n = 1'b0;
    intf.tx_valid = 1'b0;
    intf.tx_data = '0;
    intf.tx_start = 1'b0;
    intf.tx_stop = 1'b0;
    repeat (3) @(negedge clk_50);
    chk_rst("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50);
    mute = 1'b0;
    exp_q.push_back(T_START);
    exp_q.push_back(T_ACK + 8'h78);
    exp_q.push_back(T_STOP);
    send(SSD1306_ADDR_W, 1'b1, 1'b1);
    chk("ready_drop", intf.tx_ready, 1'b0);
    chk("busy_on_accept", intf.busy, 1'b1);
    cnt = 0;
    do begin
      @(posedge clk_50);
      #1 cnt++;
    end while (!intf.tx_ready && cnt < 3000);
    chk("latency", cnt, 1302);
    chk("latency_busy", intf.busy, 1'b0);
    idle_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ack_en = v[i].ack;
      if (idle_m) exp_q.push_back(T_START);
      else if (v[i].st) exp_q.push_back(T_RSTART);
      exp_q.push_back((v[i].ack ? T_ACK : T_NACK) + int'(v[i].d));
      if (v[i].exp_idle) exp_q.push_back(T_STOP);
      send(v[i].d, v[i].st, v[i].sp);
      wait_ready();
      @(negedge clk_50);
      chk($sformatf("v%0d_busy", i), intf.busy, !v[i].exp_idle);
      chk($sformatf("v%0d_scl", i), scl_o, v[i].exp_idle);
      chk($sformatf("v%0d_sda", i), sda_drive_low, !v[i].exp_idle);
      chk($sformatf("v%0d_nack", i), intf.nack_err, v[i].exp_nack);
      chk($sformatf("v%0d_tokens_left", i), exp_q.size(), 0);
      idle_m = v[i].exp_idle;
    end
    ack_en = 1'b1;
    mute = 1'b1;
    send(8'hA5, 1'b1, 1'b1);
    intf.tx_data = 8'h11;
    intf.tx_valid = 1'b1;
    extra = 0;
    repeat (484) begin
      @(negedge clk_50);
      if (intf.tx_ready) extra++;
    end
    chk("no_accept_while_busy", extra, 0);
    intf.tx_valid = 1'b0;
    @(negedge clk_50);
    rst_n = 1'b0;
    #1 chk_rst("midreset");
    @(negedge clk_50);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50);
    mute = 1'b0;
    exp_q.push_back(T_START);
    exp_q.push_back(T_ACK + 8'h78);
    exp_q.push_back(T_STOP);
    send(SSD1306_ADDR_W, 1'b1, 1'b1);
    wait_ready();
    @(negedge clk_50);
    chk("after_reset_busy", intf.busy, 1'b0);
    chk("after_reset_tokens_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
